// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_gen_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int TIME_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pg_state_t;

endpackage

// File: rtl/phase_timer.sv
// Down-counter that times one HIGH or LOW phase; expire marks the phase's last cycle.
module phase_timer
  import pulse_gen_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TIME_W-1:0] len,
  output logic              expire
);

  logic [TIME_W-1:0] r_cnt;

  // A zero length runs as one cycle, so a load of 0 and a load of 1 behave the same.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= (len == '0) ? '0 : len - TIME_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TIME_W'(1);
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Burst generator of N pulses with programmable high/low widths.
// Define PULSE_TRAIN_REPEAT_EN to add the repeat_mode input for continuous bursts.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  count_in,
  input  logic [TIME_W-1:0] high_cycles,
  input  logic [TIME_W-1:0] low_cycles,
  input  logic              abort,
`ifdef PULSE_TRAIN_REPEAT_EN
  input  logic              repeat_mode,
`endif
  output logic              signal_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  remaining
);

  pg_state_t         r_state;
  pg_state_t         w_state_next;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  w_remaining_next;
  logic [TIME_W-1:0] r_high;
  logic [TIME_W-1:0] r_low;
  logic [TIME_W-1:0] w_timer_len;
  logic              w_timer_load;
  logic              w_expire;
  logic              w_done_next;
  logic              w_accept;
  logic              w_repeat;
  logic              r_signal;
  logic              r_busy;
  logic              r_done;

`ifdef PULSE_TRAIN_REPEAT_EN
  assign w_repeat = repeat_mode;
`else
  assign w_repeat = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && start && !abort;

  phase_timer #(.TIME_W(TIME_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_timer_load),
    .len    (w_timer_len),
    .expire (w_expire)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_done_next      = 1'b0;
    w_timer_load     = 1'b0;
    w_timer_len      = r_high;

    if (abort) begin
      w_state_next     = IDLE;
      w_remaining_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_remaining_next = count_in;
            if (count_in != '0) begin
              w_state_next = HIGH;
              w_timer_load = 1'b1;
              w_timer_len  = high_cycles;
            end else begin
              w_done_next = 1'b1;
            end
          end
        end
        HIGH: begin
          if (w_expire) begin
            w_state_next = LOW;
            w_timer_load = 1'b1;
            w_timer_len  = r_low;
            if (r_remaining != '0) w_remaining_next = r_remaining - CNT_W'(1);
          end
        end
        LOW: begin
          if (w_expire) begin
            if (r_remaining != '0) begin
              w_state_next = HIGH;
              w_timer_load = 1'b1;
            end else if (w_repeat) begin
              w_state_next     = HIGH;
              w_timer_load     = 1'b1;
              w_remaining_next = r_count;
              w_done_next      = 1'b1;
            end else begin
              w_state_next = IDLE;
              w_done_next  = 1'b1;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_signal    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
      r_high      <= '0;
      r_low       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_signal    <= (w_state_next == HIGH);
      r_busy      <= (w_state_next != IDLE);
      r_done      <= w_done_next;
      if (w_accept) begin
        r_count <= count_in;
        r_high  <= high_cycles;
        r_low   <= low_cycles;
      end
    end
  end

  assign signal_out = r_signal;
  assign busy       = r_busy;
  assign done       = r_done;
  assign remaining  = r_remaining;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: vector table plus cycle-exact scoreboard.
`timescale 1ns/1ps
module tb_pulse_train_gen;
  import pulse_gen_pkg::*;

  localparam int CW = CNT_W_DEF;
  localparam int TW = TIME_W_DEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] count_in;
  logic [TW-1:0] high_cycles;
  logic [TW-1:0] low_cycles;
`ifdef PULSE_TRAIN_REPEAT_EN
  logic          repeat_mode;
`endif
  logic          signal_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] remaining;

  always #5 clk = ~clk;

  pulse_train_gen #(.CNT_W(CW), .TIME_W(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .count_in    (count_in),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .abort       (abort),
`ifdef PULSE_TRAIN_REPEAT_EN
    .repeat_mode (repeat_mode),
`endif
    .signal_out  (signal_out),
    .busy        (busy),
    .done        (done),
    .remaining   (remaining)
  );

  // Downstream receiver: 3-stage synchroniser plus rising-edge counter.
  logic        ec_clear;
  logic [3:0]  r_sync;
  int unsigned edge_count;
  always_ff @(posedge clk) begin
    if (ec_clear) begin
      r_sync     <= '0;
      edge_count <= 0;
    end else begin
      r_sync <= {r_sync[2:0], signal_out};
      if (r_sync[2] && !r_sync[3]) edge_count <= edge_count + 1;
    end
  end

  typedef struct packed {
    logic          sig;
    logic          bsy;
    logic          dn;
    logic [CW-1:0] rem;
  } obs_t;

  typedef struct {
    int n;
    int h;
    int l;
    int exp_busy;
  } vec_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic s, input logic b, input logic d, input int r);
    obs_t o;
    o.sig = s;
    o.bsy = b;
    o.dn  = d;
    o.rem = CW'(r);
    return o;
  endfunction

  // Expected per-cycle outputs of one burst, derived from the timing rules.
  task automatic push_burst(input int n, input int h, input int l, input bit first_done);
    int he, le;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < he; c++) exp_q.push_back(mk(1'b1, 1'b1, first_done && k == 0 && c == 0, n - k));
      for (int c = 0; c < le; c++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, n - k - 1));
    end
  endtask

  task automatic push_done();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 0));
  endtask

  task automatic push_idle(input int cycles);
    for (int c = 0; c < cycles; c++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
  endtask

  task automatic step(input string tag, output obs_t e);
    obs_t act;
    @(posedge clk);
    #1;
    act = {signal_out, busy, done, remaining};
    if (busy) cyc_busy++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got %0h", tag, act);
      e = mk(1'b0, 1'b0, 1'b0, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(act), 32'(e));
    end
  endtask

  // Drain the scoreboard; with noise, hammer start and the config inputs while busy.
  task automatic drain(input string tag, input bit noise);
    obs_t e;
    while (exp_q.size() != 0) begin
      step(tag, e);
      if (noise && e.bsy) begin
        start       = 1'($urandom_range(0, 1));
        count_in    = CW'($urandom);
        high_cycles = TW'($urandom);
        low_cycles  = TW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic run_burst(input string tag, input vec_t v);
    obs_t e;
    push_idle(1);
    ec_clear = 1'b1;
    step({tag, "_pre"}, e);
    ec_clear    = 1'b0;
    start       = 1'b1;
    count_in    = CW'(v.n);
    high_cycles = TW'(v.h);
    low_cycles  = TW'(v.l);
    cyc_busy    = 0;
    if (v.n != 0) push_burst(v.n, v.h, v.l, 1'b0);
    push_done();
    drain(tag, 1'b1);
    push_idle(4);
    drain({tag, "_tail"}, 1'b0);
    check({tag, "_busy_len"}, 32'(cyc_busy), 32'(v.exp_busy));
    check({tag, "_edges"}, 32'(edge_count), 32'(v.n));
  endtask

  vec_t vecs[8];
  obs_t e;
  bit   b2b;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 3,   h: 2,   l: 3, exp_busy: 15};
    vecs[1] = '{n: 0,   h: 5,   l: 5, exp_busy: 0};
    vecs[2] = '{n: 1,   h: 0,   l: 0, exp_busy: 2};
    vecs[3] = '{n: 2,   h: 1,   l: 4, exp_busy: 10};
    vecs[4] = '{n: 4,   h: 3,   l: 0, exp_busy: 16};
    vecs[5] = '{n: 255, h: 0,   l: 0, exp_busy: 510};
    vecs[6] = '{n: 200, h: 2,   l: 2, exp_busy: 800};
    vecs[7] = '{n: 1,   h: 255, l: 1, exp_busy: 256};

    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    count_in    = '0;
    high_cycles = '0;
    low_cycles  = '0;
    ec_clear    = 1'b1;
`ifdef PULSE_TRAIN_REPEAT_EN
    repeat_mode = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    push_idle(1);
    step("reset_state", e);
    reset = 1'b0;
    push_idle(2);
    drain("post_reset", 1'b0);

    for (int i = 0; i < 8; i++) run_burst($sformatf("vec%0d", i), vecs[i]);

    // Abort in the 2nd cycle of pulse 2 of a 5-pulse burst (H=3, L=2).
    start = 1'b1; count_in = 5; high_cycles = 3; low_cycles = 2;
    push_burst(5, 3, 2, 1'b0);
    while (exp_q.size() > 7) void'(exp_q.pop_back());
    for (int k = 0; k < 7; k++) begin
      step("abort_pre", e);
      start = 1'b0;
    end
    abort = 1'b1;
    start = 1'b1;
    push_idle(1);
    step("abort_next", e);
    abort = 1'b0;
    start = 1'b0;
    push_idle(3);
    drain("abort_after", 1'b0);

    // Abort and start together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; count_in = 3; high_cycles = 2; low_cycles = 2;
    push_idle(2);
    drain("abort_start", 1'b0);
    abort = 1'b0;
    run_burst("after_abort", '{n: 2, h: 2, l: 2, exp_busy: 8});

    // Back-to-back: start accepted in the cycle done is high.
    start = 1'b1; count_in = 2; high_cycles = 1; low_cycles = 1;
    push_burst(2, 1, 1, 1'b0);
    push_done();
    b2b = 1'b0;
    while (exp_q.size() != 0) begin
      step("b2b", e);
      start = 1'b0;
      if (e.dn && !b2b) begin
        b2b = 1'b1;
        start = 1'b1; count_in = 1; high_cycles = 2; low_cycles = 2;
        push_burst(1, 2, 2, 1'b0);
        push_done();
      end
    end
    push_idle(2);
    drain("b2b_tail", 1'b0);

    // Reset asserted mid-HIGH truncates the pulse on the next edge.
    start = 1'b1; count_in = 3; high_cycles = 4; low_cycles = 2;
    push_burst(3, 4, 2, 1'b0);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    drain("rst_mid_pre", 1'b0);
    reset = 1'b1;
    push_idle(1);
    step("rst_mid", e);
    reset = 1'b0;
    push_idle(2);
    drain("rst_mid_after", 1'b0);

`ifdef PULSE_TRAIN_REPEAT_EN
    // Repeat mode: done every 2(H+L) cycles until abort.
    repeat_mode = 1'b1;
    start = 1'b1; count_in = 2; high_cycles = 2; low_cycles = 1;
    push_burst(2, 2, 1, 1'b0);
    push_burst(2, 2, 1, 1'b1);
    push_burst(2, 2, 1, 1'b1);
    drain("repeat", 1'b0);
    abort = 1'b1;
    push_idle(1);
    step("repeat_abort", e);
    abort = 1'b0;
    repeat_mode = 1'b0;
    push_idle(2);
    drain("repeat_after", 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
